// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline request/response and memory bus signals of the access controller
interface mem_access_ctrl_if;
  logic        iReq;
  logic        iWrite;
  logic [2:0]  iFunct3;
  logic [31:0] iAddress;
  logic [31:0] iWriteData;
  logic        oStall;
  logic        oDone;
  logic [31:0] oReadData;
  logic [1:0]  oAlignment;
  logic        oFault;
  logic [1:0]  oFaultCause;
  logic        oBusValid;
  logic        oBusWrite;
  logic [31:0] oBusAddr;
  logic [31:0] oBusWData;
  logic [3:0]  oBusByteEn;
  logic        iBusReady;
  logic        iBusRValid;
  logic [31:0] iBusRData;
  modport master (
    input  iReq, iWrite, iFunct3, iAddress, iWriteData, iBusReady, iBusRValid, iBusRData,
    output oStall, oDone, oReadData, oAlignment, oFault, oFaultCause,
    output oBusValid, oBusWrite, oBusAddr, oBusWData, oBusByteEn
  );
  modport slave (
    output iReq, iWrite, iFunct3, iAddress, iWriteData, iBusReady, iBusRValid, iBusRData,
    input  oStall, oDone, oReadData, oAlignment, oFault, oFaultCause,
    input  oBusValid, oBusWrite, oBusAddr, oBusWData, oBusByteEn
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: turns one pipeline load/store into a bus transaction with fault and timeout handling
module mem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input logic iCLK,
  input logic iRST,
  mem_access_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RDATA, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic w_illegal, w_misaligned, w_timeout;
  logic [1:0] w_cause;
  logic [3:0] w_be;
  logic [31:0] w_wdata;
  always_comb begin
    w_illegal = bus.iFunct3 == 3'b011 || bus.iFunct3[2:1] == 2'b11 || (bus.iWrite && bus.iFunct3[2]);
    w_misaligned = (bus.iFunct3[1:0] == 2'b01 && bus.iAddress[0]) ||
                   (bus.iFunct3[1:0] == 2'b10 && bus.iAddress[1:0] != 2'b00);
    w_cause = w_illegal ? 2'b11 : w_misaligned ? 2'b01 : 2'b00;
    w_be = (!bus.iWrite || bus.iFunct3[1]) ? 4'hF :
           bus.iFunct3[0] ? 4'b0011 << bus.iAddress[1:0] : 4'b0001 << bus.iAddress[1:0];
    w_wdata = bus.iFunct3[1] ? bus.iWriteData :
              bus.iFunct3[0] ? {2{bus.iWriteData[15:0]}} : {4{bus.iWriteData[7:0]}};
    w_timeout = r_cnt == CW'(TIMEOUT - 1);
  end
  assign bus.oStall = bus.iReq && r_state != DONE;
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= IDLE;
      r_cnt <= '0;
      bus.oBusValid <= 1'b0;
      bus.oBusWrite <= 1'b0;
      bus.oBusAddr <= '0;
      bus.oBusWData <= '0;
      bus.oBusByteEn <= '0;
      bus.oDone <= 1'b0;
      bus.oFault <= 1'b0;
      bus.oFaultCause <= '0;
      bus.oReadData <= '0;
      bus.oAlignment <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.iReq) begin
          bus.oAlignment <= bus.iAddress[1:0];
          bus.oReadData <= '0;
          bus.oFaultCause <= w_cause;
          r_cnt <= '0;
          if (w_cause != 2'b00) begin
            r_state <= DONE;
            bus.oDone <= 1'b1;
            bus.oFault <= 1'b1;
          end else begin
            r_state <= REQ;
            bus.oBusValid <= 1'b1;
            bus.oBusWrite <= bus.iWrite;
            bus.oBusAddr <= {bus.iAddress[31:2], 2'b00};
            bus.oBusWData <= w_wdata;
            bus.oBusByteEn <= w_be;
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.iBusReady) begin
            bus.oBusValid <= 1'b0;
            r_cnt <= '0;
            r_state <= bus.oBusWrite ? DONE : WAIT_RDATA;
            bus.oDone <= bus.oBusWrite;
          end else if (w_timeout) begin
            bus.oBusValid <= 1'b0;
            r_state <= DONE;
            bus.oDone <= 1'b1;
            bus.oFault <= 1'b1;
            bus.oFaultCause <= 2'b10;
          end
        end
        WAIT_RDATA: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.iBusRValid) begin
            bus.oReadData <= bus.iBusRData;
            r_state <= DONE;
            bus.oDone <= 1'b1;
          end else if (w_timeout) begin
            r_state <= DONE;
            bus.oDone <= 1'b1;
            bus.oFault <= 1'b1;
            bus.oFaultCause <= 2'b10;
          end
        end
        DONE: begin
          r_state <= IDLE;
          bus.oDone <= 1'b0;
          bus.oFault <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
